npu_write_back: RTL and testbench
=================================

// Module: npu_write_back
// PURPOSE
//   Write-back engine for NPU results: accepts 16-byte result vectors (u0..u15 order) over a valid/ready
//   handshake and writes them into the four image RAM banks, one byte per bank per cycle, 4 beats/vector.
//   Counterpart of the layer read path: consumes its start_write_back/stop_write_back and produces the
//   wr_en/ram_num/ram_store_addr stream that the RAM write ports use.
// PARAMETERS
//   ADDR_W    14     width of ram_store_addr / base address
//   CNT_W     12     width of vec_count
// PORTS
//   clk               in   1       single clock, rising edge
//   reset             in   1       synchronous, active-high
//   start_write_back  in   1       1-cycle pulse: latch cfg_*, begin a write-back run
//   stop_write_back   in   1       1-cycle pulse: no further vectors; finish current, then done
//   cfg_base_addr     in   ADDR_W  first bank address of the run
//   cfg_ram_num       in   2       destination RAM group for the run
//   in_valid          in   1       result vector valid
//   in_ready          out  1       engine can accept a vector this cycle
//   in_data           in   128     byte k = in_data[8k+7:8k] = u<k>
//   wr_en             out  1       bank write strobe (all 4 banks)
//   wr_ram_num        out  2       latched cfg_ram_num
//   ram_store_addr    out  ADDR_W  write address, common to all banks
//   wr_data           out  32      bank j data = wr_data[8j+7:8j]
//   busy              out  1       high in any state but IDLE
//   done              out  1       1-cycle pulse at end of run
//   vec_count         out  CNT_W   vectors accepted this run (wraps)
//   overflow          out  1       sticky: address wrapped past 2^ADDR_W-1 this run
// BEHAVIOUR
//   - Reset (sync): state IDLE; all outputs 0; internal buffer, beat, stop_pending cleared. Reset mid-run
//     aborts immediately; wr_en low from the cycle after the reset edge.
//   - States: IDLE, ARMED, WRITE(beat 0..3), DONE. All outputs registered.
//   - IDLE: in_ready=0. start_write_back -> ARMED; addr<=cfg_base_addr, wr_ram_num<=cfg_ram_num,
//     vec_count<=0, overflow<=0, stop_pending<=0. start in any other state is ignored.
//   - Handshake: vector accepted on edge where in_valid&&in_ready; in_data captured to buffer,
//     vec_count+1. in_data must be stable only in the accept cycle.
//   - ARMED: in_ready=1. Accept -> WRITE beat0. stop with no accept -> DONE. stop and accept same
//     cycle -> vector is written, stop_pending<=1.
//   - WRITE beat b: wr_en=1, ram_store_addr=addr, wr_data byte j = u<4b+j>; addr<=addr+1 each beat.
//     Accept-to-first-wr_en latency = 1 cycle (beat0 visible in cycle after accept edge).
//   - in_ready=1 during beat3 unless stop_pending; accept in beat3 -> beat0 next cycle (back-to-back,
//     4 cycles/vector, no wr_en gap). Beat3 without accept: stop_pending -> DONE, else ARMED.
//   - stop_write_back during WRITE sets stop_pending; current vector always completes all 4 beats.
//   - Address wrap: addr 2^ADDR_W-1 +1 -> 0, overflow<=1 (sticky until next start); writing continues.
//   - DONE: done=1 for exactly one cycle, wr_en=0, in_ready=0, then IDLE. busy=0 again in IDLE.
//   - vec_count wraps modulo 2^CNT_W; no saturation.
// TESTING
//   1. reset; start base=0x0100,ram_num=2; one vector u<k>=k -> wr_en 4 cycles, addr 0x100..0x103,
//      wr_data 0x03020100,0x07060504,0x0B0A0908,0x0F0E0D0C, wr_ram_num=2; stop -> done pulse, vec_count=1.
//   2. in_valid held high, 3 vectors -> 12 consecutive wr_en cycles, addr base..base+11, no gaps,
//      vec_count=3.
//   3. stop same cycle as accept of vector 2 -> vector 2 fully written (4 beats), then DONE, in_ready=0.
//   4. base=0x3FFE, one vector -> addr 0x3FFE,0x3FFF,0x0000,0x0001; overflow=1 until next start.
//   5. reset asserted during beat1 -> next cycle wr_en=0, busy=0, all outputs 0; fresh start works.
//   6. start pulse while busy, stop while IDLE -> both ignored; run base/ram_num unchanged.

Source files
------------

// File: rtl/npu_write_back.sv
// rtl/npu_write_back.sv - NPU result write-back engine: 128-bit vectors to four byte-wide RAM banks
//
// Purpose:
//   Takes 16-byte result vectors (u0..u15) over a valid/ready handshake. Each vector goes out
//   as 4 write beats, one byte per bank per beat. The address advances by one every beat.
//   Runs are framed by start_write_back / stop_write_back pulses from the layer read path.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start_write_back      pulse: latch cfg_base_addr / cfg_ram_num, begin a run (IDLE only)
//   stop_write_back       pulse: finish the current vector, then pulse done
//   cfg_base_addr         first bank address of the run
//   cfg_ram_num           destination RAM group for the run
//   in_valid/in_ready     vector handshake; in_data byte k = u<k>
//   wr_en                 bank write strobe (all four banks)
//   wr_ram_num            RAM group latched at start
//   ram_store_addr        write address shared by all banks
//   wr_data               bank j byte = wr_data[8j+7:8j]
//   busy                  high in any state but IDLE
//   done                  one-cycle pulse at end of run
//   vec_count             vectors accepted this run (wraps)
//   overflow              sticky: address wrapped this run
module npu_write_back #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_write_back,
   input  logic              stop_write_back,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [1:0]        cfg_ram_num,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_data,
   output logic              wr_en,
   output logic [1:0]        wr_ram_num,
   output logic [ADDR_W-1:0] ram_store_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  vec_count,
   output logic              overflow
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_DONE} state_t;

   state_t            state, state_nx;
   logic [1:0]        beat, beat_nx;
   logic              stop_pending, stop_pending_nx;
   logic [127:0]      vec_buf;
   logic [ADDR_W-1:0] addr;
   logic              accept;

   // Registered next-cycle values of the outputs.
   logic              wr_en_d, in_ready_d, busy_d, done_d;
   logic [31:0]       wr_data_d;

   assign accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         beat         <= 2'd0;
         stop_pending <= 1'b0;
      end else begin
         state        <= state_nx;
         beat         <= beat_nx;
         stop_pending <= stop_pending_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx        = state;
      beat_nx         = beat;
      stop_pending_nx = stop_pending;
      case (state)
         S_IDLE: begin
            if (start_write_back) begin
               state_nx        = S_ARMED;
               stop_pending_nx = 1'b0;
            end
         end
         S_ARMED: begin
            if (accept) begin
               state_nx        = S_WRITE;
               beat_nx         = 2'd0;
               stop_pending_nx = stop_write_back;
            end else if (stop_write_back) begin
               state_nx = S_DONE;
            end
         end
         S_WRITE: begin
            if (stop_write_back)
               stop_pending_nx = 1'b1;
            if (beat != 2'd3) begin
               beat_nx = beat + 2'd1;
            end else if (accept) begin
               // Back-to-back vector: straight into beat 0, no strobe gap.
               beat_nx = 2'd0;
            end else if (stop_pending || stop_write_back) begin
               state_nx = S_DONE;
            end else begin
               state_nx = S_ARMED;
            end
         end
         S_DONE: begin
            state_nx        = S_IDLE;
            stop_pending_nx = 1'b0;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Output logic, evaluated for the next state so every output comes straight from a flop.
   always_comb begin
      wr_en_d    = (state_nx == S_WRITE);
      busy_d     = (state_nx != S_IDLE);
      done_d     = (state_nx == S_DONE);
      in_ready_d = (state_nx == S_ARMED) ||
                   ((state_nx == S_WRITE) && (beat_nx == 2'd3) && !stop_pending_nx);
      wr_data_d  = wr_data;
      if (wr_en_d) begin
         case (beat_nx)
            // Beat 0 is only ever entered on an accept edge, so the bytes come from the bus.
            2'd0:    wr_data_d = in_data[31:0];
            2'd1:    wr_data_d = vec_buf[63:32];
            2'd2:    wr_data_d = vec_buf[95:64];
            default: wr_data_d = vec_buf[127:96];
         endcase
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en          <= 1'b0;
         in_ready       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         wr_data        <= '0;
         ram_store_addr <= '0;
         wr_ram_num     <= '0;
         vec_count      <= '0;
         overflow       <= 1'b0;
         addr           <= '0;
         vec_buf        <= '0;
      end else begin
         wr_en    <= wr_en_d;
         in_ready <= in_ready_d;
         busy     <= busy_d;
         done     <= done_d;
         if (state == S_IDLE && start_write_back) begin
            addr       <= cfg_base_addr;
            wr_ram_num <= cfg_ram_num;
            vec_count  <= '0;
            overflow   <= 1'b0;
         end
         if (accept) begin
            vec_buf   <= in_data;
            vec_count <= vec_count + CNT_W'(1);
         end
         if (wr_en_d) begin
            ram_store_addr <= addr;
            wr_data        <= wr_data_d;
            addr           <= addr + ADDR_W'(1);
            if (&addr)
               overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_npu_write_back.sv
// tb/tb_npu_write_back.sv - scoreboard bench for npu_write_back
module tb_npu_write_back;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_write_back = 1'b0;
   logic         stop_write_back = 1'b0;
   logic [13:0]  cfg_base_addr = '0;
   logic [1:0]   cfg_ram_num = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         wr_en;
   logic [1:0]   wr_ram_num;
   logic [13:0]  ram_store_addr;
   logic [31:0]  wr_data;
   logic         busy;
   logic         done;
   logic [11:0]  vec_count;
   logic         overflow;

   npu_write_back #(.ADDR_W(14), .CNT_W(12)) dut (
      .clk(clk), .reset(reset),
      .start_write_back(start_write_back), .stop_write_back(stop_write_back),
      .cfg_base_addr(cfg_base_addr), .cfg_ram_num(cfg_ram_num),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .wr_en(wr_en), .wr_ram_num(wr_ram_num), .ram_store_addr(ram_store_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .vec_count(vec_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] a;
      logic [31:0] d;
      logic [1:0]  r;
   } beat_t;

   beat_t       exp_q[$];
   int          checks = 0;
   int          fails = 0;
   int          wr_cycles = 0;
   int          bursts = 0;
   logic        prev_wr = 1'b0;
   logic [13:0] exp_addr = '0;
   logic [1:0]  exp_ram = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected beat.
   always @(negedge clk) begin
      if (wr_en) begin
         beat_t e;
         wr_cycles++;
         if (!prev_wr) bursts++;
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     ram_store_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            chk("write_beat{addr,data,ram}", {ram_store_addr, wr_data, wr_ram_num}, {e.a, e.d, e.r});
         end
      end
      prev_wr = wr_en;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic start_run(input logic [13:0] base, input logic [1:0] rn);
      cfg_base_addr    = base;
      cfg_ram_num      = rn;
      start_write_back = 1'b1;
      exp_addr         = base;
      exp_ram          = rn;
      tick();
      start_write_back = 1'b0;
   endtask

   // Start pulse the DUT must ignore; the bench model is left untouched.
   task automatic raw_start(input logic [13:0] base, input logic [1:0] rn);
      cfg_base_addr    = base;
      cfg_ram_num      = rn;
      start_write_back = 1'b1;
      tick();
      start_write_back = 1'b0;
   endtask

   task automatic pulse_stop();
      stop_write_back = 1'b1;
      tick();
      stop_write_back = 1'b0;
   endtask

   function automatic logic [127:0] make_vec(input logic [7:0] seed);
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[8*k +: 8] = seed + 8'(k);
      return v;
   endfunction

   // Offer a vector; on the accept edge push the expected beats (nbeats < 4 when a reset cuts it).
   task automatic send(input logic [127:0] d, input bit with_stop, input int nbeats);
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !in_ready; i++) tick();
      chk("in_ready_seen", in_ready, 1);
      stop_write_back = with_stop;
      for (int b = 0; b < nbeats; b++) begin
         beat_t e;
         e.a = exp_addr;
         e.d = d[32*b +: 32];
         e.r = exp_ram;
         exp_q.push_back(e);
         exp_addr = exp_addr + 14'd1;
      end
      tick();
      stop_write_back = 1'b0;
      in_valid        = 1'b0;
   endtask

   task automatic wait_done(input logic [11:0] n_vec);
      for (int i = 0; i < 40 && !done; i++) tick();
      chk("done_seen", done, 1);
      chk("vec_count", vec_count, n_vec);
      chk("done_in_ready", in_ready, 0);
      chk("done_wr_en", wr_en, 0);
      tick();
      chk("done_width", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int w0, b0;

      // Reset state
      do_reset();
      chk("rst_outputs", {wr_en, in_ready, busy, done, overflow, wr_ram_num, ram_store_addr, wr_data, vec_count},
          64'h0);

      // 1: single vector u<k>=k
      start_run(14'h0100, 2'd2);
      chk("armed_busy", busy, 1);
      send(128'h0F0E0D0C0B0A09080706050403020100, 0, 4);
      pulse_stop();
      wait_done(12'd1);
      chk("t1_ram_num", wr_ram_num, 2);

      // 2: three vectors back-to-back, one gapless burst of 12 strobes
      w0 = wr_cycles;
      b0 = bursts;
      start_run(14'h0040, 2'd1);
      send(make_vec(8'h10), 0, 4);
      send(make_vec(8'h20), 0, 4);
      send(make_vec(8'h30), 0, 4);
      pulse_stop();
      wait_done(12'd3);
      chk("t2_wr_cycles", wr_cycles - w0, 12);
      chk("t2_bursts", bursts - b0, 1);

      // 3: stop in the accept cycle of vector 2; a held in_valid must not sneak in vector 3
      start_run(14'h0200, 2'd3);
      send(make_vec(8'h40), 0, 4);
      send(make_vec(8'h50), 1, 4);
      in_data  = make_vec(8'hE0);
      in_valid = 1'b1;
      wait_done(12'd2);
      in_valid = 1'b0;

      // 4: address wrap sets sticky overflow
      start_run(14'h3FFE, 2'd0);
      chk("t4_ovf_start", overflow, 0);
      send(make_vec(8'h60), 0, 4);
      pulse_stop();
      wait_done(12'd1);
      chk("t4_ovf_sticky", overflow, 1);
      start_run(14'h0010, 2'd0);
      chk("t4_ovf_cleared", overflow, 0);
      pulse_stop();
      wait_done(12'd0);

      // 5: reset during beat 1
      start_run(14'h0123, 2'd1);
      send(make_vec(8'h70), 0, 2);
      tick();
      reset = 1'b1;
      tick();
      chk("t5_rst_outputs", {wr_en, in_ready, busy, done, overflow, wr_ram_num, ram_store_addr, wr_data, vec_count},
          64'h0);
      reset = 1'b0;
      tick();
      chk("t5_idle_wr_en", wr_en, 0);
      start_run(14'h0050, 2'd2);
      send(make_vec(8'h80), 0, 4);
      pulse_stop();
      wait_done(12'd1);

      // 6: start while busy and stop while idle are ignored
      start_run(14'h0200, 2'd1);
      raw_start(14'h0300, 2'd3);
      chk("t6_ram_num_armed", wr_ram_num, 1);
      send(make_vec(8'h90), 0, 4);
      raw_start(14'h0300, 2'd3);
      pulse_stop();
      wait_done(12'd1);
      chk("t6_ram_num", wr_ram_num, 1);
      pulse_stop();
      tick();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_done", done, 0);
      chk("t6_idle_ready", in_ready, 0);

      tick();
      tick();
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
